dioptase_reset_ctrl: RTL and testbench



---
 rtl/dioptase_reset_ctrl_pkg.sv | 20 ++
 rtl/dioptase_reset_ctrl_debounce.sv | 63 ++++++
 rtl/dioptase_reset_ctrl.sv | 107 ++++++++++
 tb/tb_dioptase_reset_ctrl.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dioptase_reset_ctrl_pkg.sv
// Shared encodings for the dioptase board reset conditioner: controller states,
// reset-cause codes and the saturating press-count helper.
package dioptase_reset_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_ASSERT   = 2'd0,
        ST_WAIT_MEM = 2'd1,
        ST_RUN      = 2'd2
    } state_e;

    localparam logic CAUSE_POR = 1'b0;
    localparam logic CAUSE_BTN = 1'b1;

    localparam logic [7:0] COUNT_MAX = 8'd255;

    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        return (value == COUNT_MAX) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/dioptase_reset_ctrl_debounce.sv
// Button synchronizer plus debounce filter: a level change is accepted only after
// DEBOUNCE_CYCLES consecutive synchronized samples disagree with the stable level.
module dioptase_debounce #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic stable,
    output logic fall_pulse,
    output logic rise_pulse
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   synced_s;
    logic                   accept_s;
    logic [CNT_W-1:0]       cnt_r;
    logic                   stable_r;
    logic                   fall_r;
    logic                   rise_r;

    assign synced_s = sync_r[SYNC_STAGES-1];
    assign accept_s = (synced_s != stable_r) && (cnt_r == CNT_LAST);

    // Synchronizer chain, idles at the released (high) level.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_r <= {SYNC_STAGES{1'b1}};
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], din};
        end
    end

    // Debounce counter, accepted level and one-cycle edge pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            stable_r <= 1'b1;
            cnt_r    <= '0;
            fall_r   <= 1'b0;
            rise_r   <= 1'b0;
        end else begin
            fall_r <= accept_s && !synced_s;
            rise_r <= accept_s && synced_s;
            if (synced_s == stable_r) begin
                cnt_r <= '0;
            end else if (accept_s) begin
                stable_r <= synced_s;
                cnt_r    <= '0;
            end else begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
        end
    end

    assign stable     = stable_r;
    assign fall_pulse = fall_r;
    assign rise_pulse = rise_r;

endmodule

// File: rtl/dioptase_reset_ctrl.sv
// Board reset conditioner: debounced button, hold stretch, DDR-ready gating,
// registered active-high SoC reset plus cause flag and saturating press count.
module dioptase_reset_ctrl
    import dioptase_reset_ctrl_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int HOLD_CYCLES     = 1024,
    parameter bit WAIT_MEM_READY  = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_resetn,
    input  logic       mem_ready,
    output logic       soc_rst,
    output logic       last_cause,
    output logic [7:0] btn_reset_count
);

    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

    logic              stable_s;
    logic              fall_s;
    logic              rise_unused_s;
    state_e            state_r;
    state_e            base_nxt_s;
    state_e            state_nxt_s;
    logic [HOLD_W-1:0] hold_r;
    logic [HOLD_W-1:0] hold_nxt_s;
    logic              soc_rst_r;
    logic              last_cause_r;
    logic [7:0]        count_r;

    dioptase_debounce #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk        (clk),
        .rst        (rst),
        .din        (btn_resetn),
        .stable     (stable_s),
        .fall_pulse (fall_s),
        .rise_pulse (rise_unused_s)
    );

    // Next-state and hold-counter logic; a press always wins and restarts the hold.
    always_comb begin
        base_nxt_s = state_r;
        hold_nxt_s = '0;
        case (state_r)
            ST_ASSERT: begin
                if (!stable_s) begin
                    hold_nxt_s = '0;
                end else if (hold_r == HOLD_LAST) begin
                    base_nxt_s = ST_WAIT_MEM;
                end else begin
                    hold_nxt_s = hold_r + HOLD_W'(1);
                end
            end
            ST_WAIT_MEM: begin
                if (mem_ready || !WAIT_MEM_READY) begin
                    base_nxt_s = ST_RUN;
                end else begin
                    base_nxt_s = ST_WAIT_MEM;
                end
            end
            ST_RUN: begin
                // Calibration is one-shot: a later mem_ready drop is ignored.
                base_nxt_s = ST_RUN;
            end
            default: begin
                base_nxt_s = ST_ASSERT;
            end
        endcase
        state_nxt_s = fall_s ? ST_ASSERT : base_nxt_s;
        if (fall_s) begin
            hold_nxt_s = '0;
        end else begin
            hold_nxt_s = hold_nxt_s;
        end
    end

    // State, hold counter, registered reset output and diagnostics.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_ASSERT;
            hold_r       <= '0;
            soc_rst_r    <= 1'b1;
            last_cause_r <= CAUSE_POR;
            count_r      <= 8'd0;
        end else begin
            state_r   <= state_nxt_s;
            hold_r    <= hold_nxt_s;
            soc_rst_r <= (state_nxt_s != ST_RUN);
            if (fall_s) begin
                last_cause_r <= CAUSE_BTN;
                count_r      <= sat_inc8(count_r);
            end
        end
    end

    assign soc_rst         = soc_rst_r;
    assign last_cause      = last_cause_r;
    assign btn_reset_count = count_r;

endmodule

// File: tb/tb_dioptase_reset_ctrl.sv
// Self-checking bench for dioptase_reset_ctrl: directed timing sequences, a table of
// press/bounce patterns and randomized traffic against an elapsed-time reference model.
module tb_dioptase_reset_ctrl;

    localparam int S = 2;
    localparam int D = 4;
    localparam int H = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_resetn = 1'b1;
    logic       mem_ready = 1'b1;
    logic       soc_rst_a, cause_a, soc_rst_b, cause_b;
    logic [7:0] cnt_a, cnt_b;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    dioptase_reset_ctrl #(.SYNC_STAGES(S), .DEBOUNCE_CYCLES(D), .HOLD_CYCLES(H),
                          .WAIT_MEM_READY(1'b1)) dut_a (
        .clk(clk), .rst(rst), .btn_resetn(btn_resetn), .mem_ready(mem_ready),
        .soc_rst(soc_rst_a), .last_cause(cause_a), .btn_reset_count(cnt_a));

    dioptase_reset_ctrl #(.SYNC_STAGES(S), .DEBOUNCE_CYCLES(D), .HOLD_CYCLES(H),
                          .WAIT_MEM_READY(1'b0)) dut_b (
        .clk(clk), .rst(rst), .btn_resetn(btn_resetn), .mem_ready(mem_ready),
        .soc_rst(soc_rst_b), .last_cause(cause_b), .btn_reset_count(cnt_b));

    // Reference model: pin delayed through the synchronizer, run-length debounce,
    // and release expressed as "edges spent with the button released since the last
    // press" plus a latch recording that memory was seen ready once the hold expired.
    int   m_q[$];
    bit   m_stable, m_pend, m_mem_seen, m_cause;
    int   m_run, m_ticks, m_cnt;

    task automatic model_reset();
        m_q = {};
        for (int i = 0; i < S; i++) m_q.push_back(1);
        m_stable = 1'b1; m_pend = 1'b0; m_mem_seen = 1'b0; m_cause = 1'b0;
        m_run = 0; m_ticks = 0; m_cnt = 0;
    endtask

    task automatic model_step();
        int y;
        if (rst) begin
            model_reset();
        end else begin
            if (m_pend) begin
                m_ticks = 0; m_mem_seen = 1'b0; m_cause = 1'b1;
                if (m_cnt < 255) m_cnt++;
            end else begin
                if (m_ticks >= H && mem_ready) m_mem_seen = 1'b1;
                if (m_stable && m_ticks < H) m_ticks++;
            end
            y = m_q.pop_front();
            m_q.push_back(int'(btn_resetn));
            m_pend = 1'b0;
            if (y != int'(m_stable)) begin
                m_run++;
                if (m_run == D) begin
                    m_stable = (y != 0);
                    m_run = 0;
                    if (y == 0) m_pend = 1'b1;
                end
            end else begin
                m_run = 0;
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One clock: model advances on the edge, outputs compared on the falling edge.
    task automatic step();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check("model_soc_rst", 32'(soc_rst_a), 32'(!m_mem_seen));
        check("model_cause", 32'(cause_a), 32'(m_cause));
        check("model_count", 32'(cnt_a), 32'(m_cnt));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic count_until(input logic lvl, input int bound, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (soc_rst_a !== lvl && n < bound);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        run(3);
        rst = 1'b0;
    endtask

    typedef struct {
        int low_len;
        int high_len;
        int reps;
        int exp_inc;
        bit exp_rst_seen;
    } pat_t;

    pat_t pats[5];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n, base, rst_left, btn_left;
        bit seen;

        pats[0] = '{3, 2, 5, 0, 1'b0};
        pats[1] = '{20, 30, 1, 1, 1'b1};
        pats[2] = '{4, 30, 1, 1, 1'b1};
        pats[3] = '{3, 30, 1, 0, 1'b0};
        pats[4] = '{5, 40, 3, 3, 1'b1};

        model_reset();
        @(negedge clk);

        // Power-on release with memory ready.
        do_reset();
        check("por_soc_rst", 32'(soc_rst_a), 32'd1);
        check("por_count", 32'(cnt_a), 32'd0);
        count_until(1'b0, 20, n);
        check("por_release_edges", 32'(n), 32'(H + 1));
        check("por_cause", 32'(cause_a), 32'd0);

        // Memory wait: A holds until mem_ready, B ignores it.
        mem_ready = 1'b0;
        do_reset();
        run(H + 1);
        check("memwait_a_held", 32'(soc_rst_a), 32'd1);
        check("memwait_b_released", 32'(soc_rst_b), 32'd0);
        run(30 - (H + 1));
        check("memwait_a_still_held", 32'(soc_rst_a), 32'd1);
        mem_ready = 1'b1;
        count_until(1'b0, 10, n);
        check("memwait_release_edges", 32'(n), 32'd1);

        // Clean press from RUN: press and release latency.
        btn_resetn = 1'b0;
        count_until(1'b1, 20, n);
        check("press_latency", 32'(n), 32'(S + D + 1));
        run(20 - n);
        check("press_count", 32'(cnt_a), 32'd1);
        check("press_cause", 32'(cause_a), 32'd1);
        btn_resetn = 1'b1;
        count_until(1'b0, 40, n);
        check("release_latency", 32'(n), 32'(S + D + H + 1));

        // Table of press / bounce patterns applied from RUN.
        for (int p = 0; p < 5; p++) begin
            base = int'(cnt_a);
            seen = 1'b0;
            for (int r = 0; r < pats[p].reps; r++) begin
                btn_resetn = 1'b0;
                for (int i = 0; i < pats[p].low_len; i++) begin
                    step();
                    if (soc_rst_a) seen = 1'b1;
                end
                btn_resetn = 1'b1;
                for (int i = 0; i < pats[p].high_len; i++) begin
                    step();
                    if (soc_rst_a) seen = 1'b1;
                end
            end
            check($sformatf("pat%0d_count", p), 32'(cnt_a), 32'(base + pats[p].exp_inc));
            check($sformatf("pat%0d_rst_seen", p), 32'(seen), 32'(pats[p].exp_rst_seen));
            check($sformatf("pat%0d_run", p), 32'(soc_rst_a), 32'd0);
        end

        // Press during WAIT_MEM: hold restarts from zero after the release.
        mem_ready = 1'b0;
        do_reset();
        run(12);
        btn_resetn = 1'b0;
        run(10);
        check("waitmem_press_rst", 32'(soc_rst_a), 32'd1);
        check("waitmem_press_count", 32'(cnt_a), 32'd1);
        btn_resetn = 1'b1;
        mem_ready = 1'b1;
        count_until(1'b0, 40, n);
        check("waitmem_release_latency", 32'(n), 32'(S + D + H + 1));

        // Saturation, then reset while still in ASSERT.
        for (int k = 0; k < 260; k++) begin
            btn_resetn = 1'b0;
            run(5);
            btn_resetn = 1'b1;
            run(5);
        end
        check("sat_count", 32'(cnt_a), 32'd255);
        check("sat_in_assert", 32'(soc_rst_a), 32'd1);
        do_reset();
        check("midrst_count", 32'(cnt_a), 32'd0);
        check("midrst_cause", 32'(cause_a), 32'd0);
        count_until(1'b0, 20, n);
        check("midrst_release_edges", 32'(n), 32'(H + 1));

        // Randomized traffic against the model.
        rst_left = 0;
        btn_left = 0;
        for (int c = 0; c < 3000; c++) begin
            if (rst_left > 0) begin
                rst_left--;
                rst = (rst_left > 0);
            end else if ($urandom_range(0, 399) == 0) begin
                rst_left = int'($urandom_range(1, 3)) + 1;
                rst = 1'b1;
            end
            if (btn_left == 0) begin
                btn_resetn = ($urandom_range(0, 2) != 0);
                btn_left = int'($urandom_range(1, 12));
            end
            btn_left--;
            if ($urandom_range(0, 199) == 0) mem_ready = ~mem_ready;
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
